// File: rtl/grf_wb_arbiter_pkg.sv
// Shared types and defaults for the GRF write-back arbiter.
//   REG_ZERO      : architectural zero register, never written
//   wb_entry_t    : one buffered write {rd, wd, pc}
//   grant_e       : which producer owns the write port this cycle
package grf_wb_arbiter_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int DEFAULT_DEPTH        = 4;
  localparam int DEFAULT_STARVE_LIMIT = 3;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [31:0] pc;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_PRI,
    GRANT_SEC
  } grant_e;

endpackage

// File: rtl/grf_wb_arbiter_wb_fifo.sv
// Synchronous FIFO of wb_entry_t buffering secondary-producer results.
//   clk, rst_n : clock, async active-low reset (clears pointers only)
//   push, din  : write din at tail (ignored when full)
//   pop, dout  : dout shows head; pop advances it (ignored when empty)
//   full/empty : pointer-derived status, pointers are log2(DEPTH)+1 bits
module wb_fifo
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_entry_t   mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra MSB distinguishes full (MSBs differ) from empty (all equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; emptied pointers make stale contents unobservable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Drives the single GRF write port for two producers.
//   CLK, Reset_n          : clock, async active-low reset
//   p_valid/p_rd/p_wd/p_pc: pipeline W-stage result, no backpressure
//   p_stall               : W stage must hold (forced FIFO pop this cycle)
//   s_valid/s_ready/s_*   : variable-latency unit result, valid/ready handshake
//   RegWrite/RD/WD/WPC    : registered GRF write port, 1 cycle after grant
//   pending               : bit r set while a secondary write to $r is buffered
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        p_valid,
  input  logic [4:0]  p_rd,
  input  logic [31:0] p_wd,
  input  logic [31:0] p_pc,
  output logic        p_stall,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [4:0]  s_rd,
  input  logic [31:0] s_wd,
  input  logic [31:0] s_pc,
  output logic        RegWrite,
  output logic [4:0]  RD,
  output logic [31:0] WD,
  output logic [31:0] WPC,
  output logic [31:0] pending
);

  localparam int            CW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  wb_entry_t     head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          p_req;
  logic          cnt_inc;
  grant_e        grant;
  logic [CW-1:0] starve_cnt;
  logic [31:0]   pending_next;

  // A primary result to $0 is consumed silently and never competes.
  assign p_req   = p_valid && (p_rd != REG_ZERO);
  assign s_ready = !fifo_full;
  assign push    = s_valid && s_ready && (s_rd != REG_ZERO);
  assign pop     = (grant == GRANT_SEC);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (Reset_n),
    .push  (push),
    .din   ('{rd: s_rd, wd: s_wd, pc: s_pc}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant   = GRANT_NONE;
    p_stall = 1'b0;
    cnt_inc = 1'b0;
    if (fifo_empty) begin
      if (p_req) grant = GRANT_PRI;
    end else if (!p_req) begin
      grant = GRANT_SEC;
    end else if (starve_cnt < LIMIT) begin
      grant   = GRANT_PRI;
      cnt_inc = 1'b1;
    end else begin
      // Secondary has lost LIMIT times in a row: take the port from the pipeline.
      grant   = GRANT_SEC;
      p_stall = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      starve_cnt <= '0;
    end else if (pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (cnt_inc) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Clear before set so a same-cycle push to the popped rd leaves the bit set.
  always_comb begin
    pending_next = pending;
    if (pop)  pending_next[head.rd] = 1'b0;
    if (push) pending_next[s_rd]    = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // Address/data/PC hold their last value on idle cycles.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      RegWrite <= 1'b0;
      RD       <= '0;
      WD       <= '0;
      WPC      <= '0;
    end else begin
      unique case (grant)
        GRANT_SEC: begin
          RegWrite <= 1'b1;
          RD       <= head.rd;
          WD       <= head.wd;
          WPC      <= head.pc;
        end
        GRANT_PRI: begin
          RegWrite <= 1'b1;
          RD       <= p_rd;
          WD       <= p_wd;
          WPC      <= p_pc;
        end
        default: RegWrite <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter. Two instances share stimulus: dut uses the
// default STARVE_LIMIT=3, dut_b uses STARVE_LIMIT=15 for the backpressure case.
module tb_grf_wb_arbiter;

  logic        CLK;
  logic        Reset_n;
  logic        p_valid, s_valid;
  logic [4:0]  p_rd, s_rd;
  logic [31:0] p_wd, p_pc, s_wd, s_pc;

  logic        p_stall, s_ready, RegWrite;
  logic [4:0]  RD;
  logic [31:0] WD, WPC, pending;

  logic        p_stall_b, s_ready_b, RegWrite_b;
  logic [4:0]  RD_b;
  logic [31:0] WD_b, WPC_b, pending_b;

  logic        sel_b;
  int          checks;
  int          failures;

  grf_wb_arbiter dut (
    .CLK(CLK), .Reset_n(Reset_n),
    .p_valid(p_valid), .p_rd(p_rd), .p_wd(p_wd), .p_pc(p_pc), .p_stall(p_stall),
    .s_valid(s_valid), .s_ready(s_ready), .s_rd(s_rd), .s_wd(s_wd), .s_pc(s_pc),
    .RegWrite(RegWrite), .RD(RD), .WD(WD), .WPC(WPC), .pending(pending)
  );

  grf_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(15)) dut_b (
    .CLK(CLK), .Reset_n(Reset_n),
    .p_valid(p_valid), .p_rd(p_rd), .p_wd(p_wd), .p_pc(p_pc), .p_stall(p_stall_b),
    .s_valid(s_valid), .s_ready(s_ready_b), .s_rd(s_rd), .s_wd(s_wd), .s_pc(s_pc),
    .RegWrite(RegWrite_b), .RD(RD_b), .WD(WD_b), .WPC(WPC_b), .pending(pending_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_p(input logic v, input logic [4:0] rd, input logic [31:0] wd, input logic [31:0] pc);
    p_valid = v; p_rd = rd; p_wd = wd; p_pc = pc;
  endtask

  // Offering a destination that is still pending breaks the producer contract.
  task automatic set_s(input logic v, input logic [4:0] rd, input logic [31:0] wd, input logic [31:0] pc);
    if (v && rd != 5'd0)
      check("contract_pending_clear", sel_b ? pending_b[rd] : pending[rd], 32'd0);
    s_valid = v; s_rd = rd; s_wd = wd; s_pc = pc;
  endtask

  task automatic reset_pulse;
    Reset_n = 1'b0;
    #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] e;
    checks   = 0;
    failures = 0;
    sel_b    = 1'b0;
    Reset_n  = 1'b0;
    set_p(0, 0, 0, 0);
    set_s(0, 0, 0, 0);
    repeat (2) tick;
    check("por_regwrite", RegWrite, 0);
    check("por_pending", pending, 0);
    check("por_s_ready", s_ready, 1);
    check("por_p_stall", p_stall, 0);
    Reset_n = 1'b1;

    // Fill three entries while the primary keeps the port busy.
    set_p(1, 1, 32'h11, 32'h100);
    set_s(1, 10, 32'hA10, 32'h2000); tick;
    set_s(1, 11, 32'hA11, 32'h2004); tick;
    set_s(1, 12, 32'hA12, 32'h2008); tick;
    set_s(0, 0, 0, 0);
    check("fill_pending", pending, 32'h0000_1C00);
    check("fill_rd", RD, 1);

    // Mid-cycle asynchronous reset.
    #2;
    Reset_n = 1'b0;
    #1;
    check("rst_regwrite", RegWrite, 0);
    check("rst_rd", RD, 0);
    check("rst_wd", WD, 0);
    check("rst_wpc", WPC, 0);
    check("rst_pending", pending, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_p_stall", p_stall, 0);
    set_p(0, 0, 0, 0);
    tick;
    Reset_n = 1'b1;
    set_p(1, 5, 32'h1234, 32'h3000); tick;
    check("post_rst_regwrite", RegWrite, 1);
    check("post_rst_rd", RD, 5);
    check("post_rst_wd", WD, 32'h1234);
    check("post_rst_wpc", WPC, 32'h3000);
    check("post_rst_pending", pending, 0);
    set_p(0, 0, 0, 0); tick;
    check("post_rst_fifo_empty", RegWrite, 0);
    check("idle_rd_hold", RD, 5);

    // Secondary only.
    set_s(1, 8, 32'hAAAA, 32'h3010);
    #1 check("sec_s_ready", s_ready, 1);
    tick;
    check("sec_pending_set", pending, 32'h0000_0100);
    check("sec_no_write_yet", RegWrite, 0);
    set_s(0, 0, 0, 0); tick;
    check("sec_regwrite", RegWrite, 1);
    check("sec_rd", RD, 8);
    check("sec_wd", WD, 32'hAAAA);
    check("sec_wpc", WPC, 32'h3010);
    check("sec_pending_clr", pending, 0);

    // Starvation: rd=9 buffered, primary rd=1..4.
    set_p(1, 7, 32'h77, 32'h3100);
    set_s(1, 9, 32'h9999, 32'h3020); tick;
    set_s(0, 0, 0, 0);
    check("starve_pre_rd", RD, 7);
    check("starve_pending", pending, 32'h0000_0200);
    for (int i = 1; i <= 3; i++) begin
      set_p(1, 5'(i), 32'h10 + 32'(i), 32'h3200 + 32'(4 * i));
      #1 check("starve_no_stall", p_stall, 0);
      tick;
      check("starve_pri_rd", RD, 32'(i));
    end
    set_p(1, 4, 32'h14, 32'h3210);
    #1 check("starve_forced_stall", p_stall, 1);
    tick;
    check("starve_sec_rd", RD, 9);
    check("starve_sec_wd", WD, 32'h9999);
    check("starve_pending_clr", pending, 0);
    #1 check("starve_represent_no_stall", p_stall, 0);
    tick;
    check("starve_pri4_rd", RD, 4);
    check("starve_pri4_wd", WD, 32'h14);
    set_p(0, 0, 0, 0); tick;
    check("starve_idle", RegWrite, 0);

    // Full / backpressure on the STARVE_LIMIT=15 instance.
    reset_pulse();
    sel_b = 1'b1;
    set_p(1, 20, 32'h20, 32'h3300);
    for (int k = 0; k < 4; k++) begin
      set_s(1, 5'(16 + k), 32'hB0 + 32'(k), 32'h4000 + 32'(4 * k));
      tick;
    end
    set_s(1, 21, 32'hB4, 32'h4010);
    #1 check("full_s_ready", s_ready_b, 0);
    check("full_pending", pending_b, 32'h000F_0000);
    check("full_no_stall", p_stall_b, 0);
    tick;
    check("full_held_pending", pending_b, 32'h000F_0000);
    check("full_pri_rd", RD_b, 20);
    check("full_still_full", s_ready_b, 0);
    set_p(0, 0, 0, 0); tick;
    check("drain0_rd", RD_b, 16);
    check("drain0_wd", WD_b, 32'hB0);
    check("drain0_wpc", WPC_b, 32'h4000);
    check("drain0_s_ready", s_ready_b, 1);
    tick;
    set_s(0, 0, 0, 0);
    check("drain1_rd", RD_b, 17);
    check("drain1_pending", pending_b, 32'h002C_0000);
    tick; check("drain2_rd", RD_b, 18);
    tick; check("drain3_rd", RD_b, 19);
    tick;
    check("drain4_rd", RD_b, 21);
    check("drain4_wd", WD_b, 32'hB4);
    tick;
    check("drain_idle", RegWrite_b, 0);
    check("drain_pending", pending_b, 0);

    // Zero register from both producers.
    reset_pulse();
    sel_b = 1'b0;
    set_p(1, 0, 32'hDEAD, 32'h3400);
    set_s(1, 0, 32'hBEEF, 32'h3404);
    #1 check("zero_s_ready", s_ready, 1);
    check("zero_p_stall", p_stall, 0);
    tick;
    check("zero_no_write", RegWrite, 0);
    check("zero_pending", pending, 0);
    set_p(0, 0, 0, 0);
    set_s(0, 0, 0, 0);
    tick;
    check("zero_fifo_empty", RegWrite, 0);

    // Simultaneous push/pop at occupancy 2, through pointer wrap.
    set_p(1, 3, 32'h33, 32'h3500);
    set_s(1, 22, 32'hC000 + 22, 32'h5000 + 4 * 22); tick;
    set_s(1, 23, 32'hC000 + 23, 32'h5000 + 4 * 23); tick;
    check("pp_fill_rd", RD, 3);
    check("pp_fill_pending", pending, 32'h00C0_0000);
    set_p(0, 0, 0, 0);
    for (int n = 0; n < 4; n++) begin
      set_s(1, 5'(24 + n), 32'hC000 + 32'(24 + n), 32'h5000 + 32'(4 * (24 + n)));
      tick;
      e = (32'd1 << (23 + n)) | (32'd1 << (24 + n));
      check("pp_rd", RD, 32'(22 + n));
      check("pp_wd", WD, 32'hC000 + 32'(22 + n));
      check("pp_occupancy", pending, e);
    end
    set_s(0, 0, 0, 0);
    tick; check("pp_tail0_rd", RD, 26);
    tick;
    check("pp_tail1_rd", RD, 27);
    check("pp_tail1_wpc", WPC, 32'h5000 + 4 * 27);
    check("pp_tail_pending", pending, 0);
    tick; check("pp_idle", RegWrite, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
